// File: rtl/cpu_exec_datapath.sv
// cpu_exec_datapath: PC register with step adder, plus a combinational ALU
// whose second operand is chosen from the raw, negated or immediate value.

module mux2_1 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = sel ? a : b;
endmodule

module cpu_exec_datapath #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 32,
    parameter int PC_STEP = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] OPERAND1,
    input  logic [DATA_W-1:0] OPERAND2,
    input  logic [DATA_W-1:0] IMMEDIATE,
    input  logic [2:0]        ALUOP,
    input  logic              IS_ADD,
    input  logic              IS_IMMEDIATE,
    output logic [PC_W-1:0]   PC,
    output logic [PC_W-1:0]   PC_NEXT,
    output logic [DATA_W-1:0] ALURESULT,
    output logic              ZERO
);
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] neg, b_sel, b_op;

    always_comb begin
        PC_NEXT = pc_q + PC_W'(PC_STEP);
        pc_d    = RESET ? '0 : PC_NEXT;
    end

    always_ff @(posedge CLK) pc_q <= pc_d;

    assign PC  = pc_q;
    assign neg = ~OPERAND2 + DATA_W'(1);

    mux2_1 #(.W(DATA_W)) u_mux_add (.sel(IS_ADD), .a(OPERAND2), .b(neg), .y(b_sel));
    mux2_1 #(.W(DATA_W)) u_mux_imm (.sel(IS_IMMEDIATE), .a(IMMEDIATE), .b(b_sel), .y(b_op));

    // Reserved opcodes yield zero so ZERO reads high for them.
    always_comb begin
        ALURESULT = '0;
        case (ALUOP)
            3'b000:  ALURESULT = b_op;
            3'b001:  ALURESULT = OPERAND1 + b_op;
            3'b010:  ALURESULT = OPERAND1 & b_op;
            3'b011:  ALURESULT = OPERAND1 | b_op;
            default: ALURESULT = '0;
        endcase
        ZERO = (ALURESULT == '0);
    end
endmodule

// File: tb/tb_cpu_exec_datapath.sv
// tb_cpu_exec_datapath: directed checks of PC sequencing, wrap and the ALU.
module tb_cpu_exec_datapath;
    logic        CLK = 0, RESET = 1;
    logic [7:0]  op1 = 0, op2 = 0, imm = 0;
    logic [2:0]  aluop = 0;
    logic        is_add = 1, is_imm = 0;
    logic [31:0] pc, pc_next;
    logic [7:0]  res, s_res;
    logic        zero, s_zero;
    logic [7:0]  s_pc, s_pc_next;
    int          n_cmp = 0, n_bad = 0;

    cpu_exec_datapath dut (
        .CLK(CLK), .RESET(RESET), .OPERAND1(op1), .OPERAND2(op2), .IMMEDIATE(imm),
        .ALUOP(aluop), .IS_ADD(is_add), .IS_IMMEDIATE(is_imm),
        .PC(pc), .PC_NEXT(pc_next), .ALURESULT(res), .ZERO(zero)
    );

    cpu_exec_datapath #(.PC_W(8)) dut_s (
        .CLK(CLK), .RESET(RESET), .OPERAND1(op1), .OPERAND2(op2), .IMMEDIATE(imm),
        .ALUOP(aluop), .IS_ADD(is_add), .IS_IMMEDIATE(is_imm),
        .PC(s_pc), .PC_NEXT(s_pc_next), .ALURESULT(s_res), .ZERO(s_zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] i,
                       input logic [2:0] op, input logic add, input logic im,
                       input logic [7:0] exp, input string tag);
        op1 = a; op2 = b; imm = i; aluop = op; is_add = add; is_imm = im;
        #1;
        chk({tag, "_res"}, {24'b0, res}, {24'b0, exp});
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 8'h00});
    endtask

    initial begin
        RESET = 1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            chk("rst_pc", pc, 32'd0);
            chk("rst_pc_next", pc_next, 32'd4);
        end
        @(negedge CLK) RESET = 0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK); #1;
            chk("run_pc", pc, 32'(4 * i));
            chk("run_pc_next", pc_next, 32'(4 * i + 4));
        end
        for (int i = 4; i <= 63; i++) @(posedge CLK);
        #1;
        chk("small_pc_top", {24'b0, s_pc}, 32'h000000FC);
        chk("small_pc_next_wrap", {24'b0, s_pc_next}, 32'h00000000);
        @(posedge CLK); #1;
        chk("small_pc_wrap", {24'b0, s_pc}, 32'h00000000);
        chk("big_pc_256", pc, 32'd256);

        @(negedge CLK);
        force dut.pc_q = 32'hFFFFFFFC;
        #1;
        chk("force_pc", pc, 32'hFFFFFFFC);
        chk("force_pc_next_wrap", pc_next, 32'h00000000);
        release dut.pc_q;

        @(negedge CLK) RESET = 1;
        #1;
        chk("reset_no_async", {24'b0, s_pc}, 32'h00000004);
        @(posedge CLK); #1;
        chk("midrun_reset_pc", pc, 32'd0);
        chk("midrun_reset_small", {24'b0, s_pc}, 32'd0);
        @(posedge CLK); #1;
        chk("reset_hold", pc, 32'd0);
        @(negedge CLK) RESET = 0;
        @(posedge CLK); #1;
        chk("first_after_reset", pc, 32'd4);

        alu(8'h05, 8'h03, 8'h00, 3'b001, 1, 0, 8'h08, "add");
        alu(8'h05, 8'h03, 8'h00, 3'b001, 0, 0, 8'h02, "sub");
        alu(8'h05, 8'h05, 8'h00, 3'b001, 0, 0, 8'h00, "sub_zero");
        alu(8'h00, 8'h80, 8'h00, 3'b000, 0, 0, 8'h80, "neg_80");
        alu(8'h00, 8'h00, 8'h00, 3'b000, 0, 0, 8'h00, "neg_0");
        alu(8'h00, 8'h01, 8'h00, 3'b000, 0, 0, 8'hFF, "neg_1");
        alu(8'h00, 8'h3C, 8'hA5, 3'b000, 0, 1, 8'hA5, "fwd_imm");
        alu(8'h00, 8'hFF, 8'hA5, 3'b000, 1, 1, 8'hA5, "fwd_imm_op2");
        alu(8'h00, 8'h3C, 8'hA5, 3'b000, 1, 0, 8'h3C, "fwd_op2");
        alu(8'hF0, 8'h3C, 8'h00, 3'b010, 1, 0, 8'h30, "and");
        alu(8'hF0, 8'h3C, 8'h00, 3'b011, 1, 0, 8'hFC, "or");
        alu(8'hF0, 8'h3C, 8'h00, 3'b101, 1, 0, 8'h00, "rsv_101");
        alu(8'hF0, 8'h3C, 8'h00, 3'b100, 1, 0, 8'h00, "rsv_100");
        alu(8'hF0, 8'h3C, 8'h00, 3'b111, 1, 0, 8'h00, "rsv_111");
        alu(8'hFF, 8'h00, 8'h01, 3'b001, 1, 1, 8'h00, "add_carry");
        alu(8'h0F, 8'h0F, 8'hF0, 3'b010, 0, 1, 8'h00, "and_imm");
        alu(8'h12, 8'h34, 8'h00, 3'b011, 0, 0, 8'hDE, "or_neg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_exec_datapath.md
CPU_EXEC_DATAPATH -- requirements
Module: cpu_exec_datapath

Interface
REQ-001 Parameter DATA_W, default 8, ALU operand and result width.
REQ-002 Parameter PC_W, default 32, program counter width.
REQ-003 Parameter PC_STEP, default 4, PC increment per clock.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 OPERAND1  input  DATA_W  ALU first operand (register read port 1).
REQ-008 OPERAND2  input  DATA_W  raw second operand (register read port 2).
REQ-009 IMMEDIATE  input  DATA_W  immediate value from the instruction.
REQ-010 ALUOP  input  3  ALU operation select.
REQ-011 IS_ADD  input  1  1 = pass OPERAND2 unchanged; 0 = use its two's complement.
REQ-012 IS_IMMEDIATE  input  1  1 = second operand is IMMEDIATE; 0 = output of the IS_ADD stage.
REQ-013 PC  output  PC_W  registered program counter.
REQ-014 PC_NEXT  output  PC_W  combinational PC + PC_STEP (adder output).
REQ-015 ALURESULT  output  DATA_W  combinational ALU result.
REQ-016 ZERO  output  1  combinational, 1 when ALURESULT == 0.

Function
REQ-017 Adder: PC_NEXT SHALL equal (PC + PC_STEP) mod 2^PC_W; wrap without flag.
REQ-018 At each rising CLK with RESET=0, PC SHALL load PC_NEXT (one-cycle latency, one step per clock).
REQ-019 Negation stage: NEG = (~OPERAND2 + 1) mod 2^DATA_W; OPERAND2=0 -> 0; OPERAND2=0x80 -> 0x80.
REQ-020 Mux 1 (mux2_1): B_SEL = IS_ADD ? OPERAND2 : NEG.
REQ-021 Mux 2 (mux2_1): B_OP = IS_IMMEDIATE ? IMMEDIATE : B_SEL; IS_IMMEDIATE takes priority over IS_ADD.
REQ-022 mux2_1 semantics: select=1 SHALL choose the first data input, select=0 the second; purely combinational.
REQ-023 ALUOP 000 FORWARD: ALURESULT = B_OP.
REQ-024 ALUOP 001 ADD: ALURESULT = (OPERAND1 + B_OP) mod 2^DATA_W; carry discarded; with IS_ADD=0 this implements SUB.
REQ-025 ALUOP 010 AND: ALURESULT = OPERAND1 & B_OP.
REQ-026 ALUOP 011 OR: ALURESULT = OPERAND1 | B_OP.
REQ-027 ALUOP 100-111 (reserved): ALURESULT SHALL be 0, so ZERO = 1.
REQ-028 ALURESULT and ZERO SHALL be settled combinationally in the same cycle; the ALU holds no state and ignores CLK/RESET.
REQ-029 No X propagation: all outputs are defined for every input combination.

Reset
REQ-030 Rising CLK with RESET=1: PC SHALL become 0; PC_NEXT then reads PC_STEP.
REQ-031 RESET SHALL have priority over the increment; PC holds 0 for every cycle RESET stays high.
REQ-032 The first rising edge after RESET deasserts SHALL load PC = PC_STEP.
REQ-033 Asserting RESET mid-run SHALL take effect at the next rising edge only; there is no asynchronous PC change.
REQ-034 Before the first reset, PC is unspecified; the bench SHALL apply reset first.

Verification
REQ-035 RESET=1 for 2 clocks, then 0 for 3 clocks -> PC = 0, 0, then 4, 8, 12; PC_NEXT = PC + 4 throughout.
REQ-036 Force PC to 0xFFFFFFFC (the bench clocks up to that value or forces it), clock once -> PC = 0x00000000.
REQ-037 OPERAND1=0x05, OPERAND2=0x03, IS_ADD=1, IS_IMMEDIATE=0, ALUOP=001 -> ALURESULT=0x08, ZERO=0; then IS_ADD=0 -> 0x02; OPERAND2=0x05, IS_ADD=0 -> 0x00, ZERO=1.
REQ-038 IMMEDIATE=0xA5, IS_IMMEDIATE=1, IS_ADD=0, ALUOP=000 -> ALURESULT=0xA5, regardless of OPERAND2.
REQ-039 OPERAND1=0xF0, OPERAND2=0x3C, IS_ADD=1, IS_IMMEDIATE=0: ALUOP=010 -> 0x30; ALUOP=011 -> 0xFC; ALUOP=101 -> 0x00, ZERO=1.
REQ-040 OPERAND1=0xFF, IMMEDIATE=0x01, IS_IMMEDIATE=1, ALUOP=001 -> ALURESULT=0x00, ZERO=1 (carry dropped).
